// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry FIFO carrying {instruction, PC, CPSR flags}
// from fetch to decode with a valid/ready handshake on both sides.
// A flush empties the queue on a taken branch.
// Optional build macro FDQ_PERF_CNT_EN adds saturating stall/full cycle counters.
module fetch_decode_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int FLAG_W  = 4,
    parameter int DEPTH   = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instructionIN,
    input  logic [PC_W-1:0]    pcValIN,
    input  logic [FLAG_W-1:0]  CPSRFlags_In,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instructionOUT,
    output logic [PC_W-1:0]    pcValOUT,
    output logic [FLAG_W-1:0]  CPSRFlags_OUT,
    output logic [CNT_W-1:0]   occupancy
`ifdef FDQ_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        full_cycles
`endif
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [FLAG_W-1:0]  flags_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake status depends only on the stored count, never on the other side.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign occupancy = count;

    // Flush blocks both transfers in the cycle it is asserted.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Head entry presented directly, forced to zero while the queue is empty.
    assign instructionOUT = out_valid ? instr_q[rd_ptr] : '0;
    assign pcValOUT       = out_valid ? pc_q[rd_ptr]    : '0;
    assign CPSRFlags_OUT  = out_valid ? flags_q[rd_ptr] : '0;

    // Queue storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                flags_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= instructionIN;
                pc_q[wr_ptr]    <= pcValIN;
                flags_q[wr_ptr] <= CPSRFlags_In;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FDQ_PERF_CNT_EN
    // Saturating event counters; only reset clears them, flush does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            full_cycles  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (in_valid && !in_ready && (full_cycles != '1)) begin
                full_cycles <= full_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed vector table on a DEPTH=2 instance,
// reset/flush corner sequences, then random traffic on DEPTH=2 and DEPTH=4
// instances checked against queue-based reference models.
module tb_fetch_decode_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic [3:0]  flags_in = '0;

    logic        o2_in_ready, o2_out_valid;
    logic [31:0] o2_instr, o2_pc;
    logic [3:0]  o2_flags;
    logic [1:0]  o2_occ;

    logic        o4_in_ready, o4_out_valid;
    logic [31:0] o4_instr, o4_pc;
    logic [3:0]  o4_flags;
    logic [2:0]  o4_occ;

`ifdef FDQ_PERF_CNT_EN
    logic [31:0] o2_stall, o2_full, o4_stall, o4_full;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(2)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o2_in_ready),
        .instructionIN(instr_in), .pcValIN(pc_in), .CPSRFlags_In(flags_in),
        .flush(flush),
        .out_valid(o2_out_valid), .out_ready(out_ready),
        .instructionOUT(o2_instr), .pcValOUT(o2_pc), .CPSRFlags_OUT(o2_flags),
        .occupancy(o2_occ)
`ifdef FDQ_PERF_CNT_EN
        , .stall_cycles(o2_stall), .full_cycles(o2_full)
`endif
    );

    fetch_decode_queue #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(o4_in_ready),
        .instructionIN(instr_in), .pcValIN(pc_in), .CPSRFlags_In(flags_in),
        .flush(flush),
        .out_valid(o4_out_valid), .out_ready(out_ready),
        .instructionOUT(o4_instr), .pcValOUT(o4_pc), .CPSRFlags_OUT(o4_flags),
        .occupancy(o4_occ)
`ifdef FDQ_PERF_CNT_EN
        , .stall_cycles(o4_stall), .full_cycles(o4_full)
`endif
    );

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [67:0] din;
        logic        ev;
        logic        er;
        logic [1:0]  eocc;
        logic [67:0] edat;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] wd(input int n);
        return {32'hA000_0000 + 32'(n), 32'h100 + 32'(4 * n), 4'(n)};
    endfunction

    function automatic vec_t mk(input logic iv, input logic fl, input logic ordy, input logic [67:0] din,
                                input logic ev, input logic er, input logic [1:0] eocc,
                                input logic [67:0] edat);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.din = din;
        v.ev = ev; v.er = er; v.eocc = eocc; v.edat = edat;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [67:0] din);
        in_valid  = iv;
        flush     = fl;
        out_ready = ordy;
        {instr_in, pc_in, flags_in} = din;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 68'h0);
        #2 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [67:0] q2[$];
    logic [67:0] q4[$];

    initial begin
        logic [67:0] a_word;
        logic [67:0] din;
        logic p2, d2, p4, d4;
        int st2, fu2, st4, fu4;

        a_word = {32'hE3A01005, 32'h0000_0010, 4'b0100};
        tbl[0]  = mk(1, 0, 1, a_word, 1, 1, 1, a_word);
        tbl[1]  = mk(0, 0, 1, 68'h0,  0, 1, 0, 68'h0);
        tbl[2]  = mk(1, 0, 0, wd(2),  1, 1, 1, wd(2));
        tbl[3]  = mk(1, 0, 0, wd(3),  1, 0, 2, wd(2));
        tbl[4]  = mk(1, 0, 0, wd(4),  1, 0, 2, wd(2));
        tbl[5]  = mk(0, 0, 1, 68'h0,  1, 1, 1, wd(3));
        tbl[6]  = mk(0, 0, 1, 68'h0,  0, 1, 0, 68'h0);
        tbl[7]  = mk(1, 0, 0, wd(5),  1, 1, 1, wd(5));
        tbl[8]  = mk(1, 0, 1, wd(6),  1, 1, 1, wd(6));
        tbl[9]  = mk(1, 0, 0, wd(7),  1, 0, 2, wd(6));
        tbl[10] = mk(1, 1, 1, wd(8),  0, 1, 0, 68'h0);
        tbl[11] = mk(0, 0, 0, 68'h0,  0, 1, 0, 68'h0);
        tbl[12] = mk(1, 0, 1, wd(9),  1, 1, 1, wd(9));
        tbl[13] = mk(1, 0, 1, wd(10), 1, 1, 1, wd(10));
        tbl[14] = mk(0, 0, 0, 68'h0,  1, 1, 1, wd(10));
        tbl[15] = mk(0, 0, 1, 68'h0,  0, 1, 0, 68'h0);

        do_reset();
        chk("rst_valid", 128'(o2_out_valid), 128'(0));
        chk("rst_ready", 128'(o2_in_ready), 128'(1));
        chk("rst_occ", 128'(o2_occ), 128'(0));
        chk("rst_data", 128'({o2_instr, o2_pc, o2_flags}), 128'(0));

        // Directed vector table on the DEPTH=2 instance.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].din);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 128'(o2_out_valid), 128'(tbl[i].ev));
            chk($sformatf("vec%0d_ready", i), 128'(o2_in_ready), 128'(tbl[i].er));
            chk($sformatf("vec%0d_occ", i), 128'(o2_occ), 128'(tbl[i].eocc));
            chk($sformatf("vec%0d_data", i), 128'({o2_instr, o2_pc, o2_flags}), 128'(tbl[i].edat));
        end

        // Asynchronous reset in the middle of a cycle with two entries held.
        drive(1, 0, 0, wd(20));
        @(posedge clk); #1;
        drive(1, 0, 0, wd(21));
        @(posedge clk); #1;
        drive(0, 0, 0, 68'h0);
        chk("mid_pre_occ", 128'(o2_occ), 128'(2));
        #3 reset = 1'b1;
        #1;
        chk("mid_valid", 128'(o2_out_valid), 128'(0));
        chk("mid_ready", 128'(o2_in_ready), 128'(1));
        chk("mid_occ", 128'(o2_occ), 128'(0));
        chk("mid_data", 128'({o2_instr, o2_pc, o2_flags}), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef FDQ_PERF_CNT_EN
        do_reset();
        drive(1, 0, 0, wd(30));
        @(posedge clk); #1;
        drive(0, 0, 0, 68'h0);
        repeat (7) @(posedge clk);
        #1;
        chk("perf_stall7", 128'(o2_stall), 128'(7));
        chk("perf_stall7_d4", 128'(o4_stall), 128'(7));
        drive(0, 1, 1, 68'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 68'h0);
        @(posedge clk); #1;
        chk("perf_flush_keep", 128'(o2_stall), 128'(7));
        chk("perf_flush_occ", 128'(o2_occ), 128'(0));
        chk("perf_full0", 128'(o2_full), 128'(0));
`endif

        // Random traffic against queue models for both depths.
        do_reset();
        q2.delete();
        q4.delete();
        st2 = 0; fu2 = 0; st4 = 0; fu4 = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            chk("r2_valid", 128'(o2_out_valid), 128'(q2.size() != 0));
            chk("r2_ready", 128'(o2_in_ready), 128'(q2.size() < 2));
            chk("r2_occ", 128'(o2_occ), 128'(q2.size()));
            chk("r2_data", 128'({o2_instr, o2_pc, o2_flags}), 128'((q2.size() != 0) ? q2[0] : 68'h0));
            chk("r4_valid", 128'(o4_out_valid), 128'(q4.size() != 0));
            chk("r4_ready", 128'(o4_in_ready), 128'(q4.size() < 4));
            chk("r4_occ", 128'(o4_occ), 128'(q4.size()));
            chk("r4_data", 128'({o4_instr, o4_pc, o4_flags}), 128'((q4.size() != 0) ? q4[0] : 68'h0));
`ifdef FDQ_PERF_CNT_EN
            chk("r2_stall", 128'(o2_stall), 128'(st2));
            chk("r2_full", 128'(o2_full), 128'(fu2));
            chk("r4_stall", 128'(o4_stall), 128'(st4));
            chk("r4_full", 128'(o4_full), 128'(fu4));
`endif
            din = {$urandom, $urandom, 4'($urandom)};
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), din);

            p2 = in_valid && (q2.size() < 2) && !flush;
            d2 = (q2.size() != 0) && out_ready && !flush;
            p4 = in_valid && (q4.size() < 4) && !flush;
            d4 = (q4.size() != 0) && out_ready && !flush;
            if ((q2.size() != 0) && !out_ready) st2++;
            if (in_valid && (q2.size() >= 2)) fu2++;
            if ((q4.size() != 0) && !out_ready) st4++;
            if (in_valid && (q4.size() >= 4)) fu4++;

            @(posedge clk);
            #1;

            if (flush) begin
                q2.delete();
                q4.delete();
            end else begin
                if (d2) void'(q2.pop_front());
                if (p2) q2.push_back(din);
                if (d4) void'(q4.pop_front());
                if (p4) q4.push_back(din);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
